stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Input/timing front end for the stopwatch counter.
//   - Synchronises and debounces the pause and clear buttons; synchronises the adjust/select switches.
//   - Divides the board clock into 1 Hz, 2 Hz and display-refresh ticks.
//   - Drives count enable/clear, adjust selects and blink straight into the minutes/seconds counter.
//   - Sits between the board pins and the counter; tick_fast also feeds the seven-segment scan.
// PARAMETERS
//   DB_CYCLES  1_000_000    cycles a raw button must hold a new level before its debounced level follows (10 ms @ 100 MHz)
//   TICK_DIV   100_000_000  clk cycles per tick_1hz; must be even and >= 4
//   FAST_DIV   200_000      clk cycles per tick_fast (500 Hz display refresh); >= 2
// PORTS
//   clk        in   1  system clock, 100 MHz
//   reset      in   1  synchronous, active-high
//   btn_pause  in   1  raw pause button, asynchronous
//   btn_rst    in   1  raw clear button, asynchronous
//   sw_adj     in   1  raw adjust-mode switch
//   sw_sel     in   1  raw select switch: 0 = minutes, 1 = seconds
//   tick_1hz   out  1  1-cycle pulse every TICK_DIV cycles
//   tick_2hz   out  1  1-cycle pulse every TICK_DIV/2 cycles
//   tick_fast  out  1  1-cycle pulse every FAST_DIV cycles
//   cnt_en     out  1  1-cycle advance pulse to the counter
//   cnt_clr    out  1  1-cycle clear pulse to the counter
//   adj_min    out  1  level: adjusting minutes
//   adj_sec    out  1  level: adjusting seconds
//   paused     out  1  level: 1 while the FSM is in PAUSED
//   blink      out  1  1 Hz square wave, toggles on every tick_2hz
// BEHAVIOUR
//   Reset values
//   - All outputs 0. FSM = RUN. All dividers = 0.
//   - Synchronisers and debounced levels = 0; debounce counters = 0.
//   Synchronisers
//   - Every raw input passes a 2-FF synchroniser.
//   - Switches are not debounced: adj_min = adj & ~sel and adj_sec = adj & sel, registered.
//   - Switch latency: 3 cycles from pin to output.
//   Debounce (per button)
//   - Counter increments while the synced level differs from the debounced level; clears otherwise.
//   - When the counter reaches DB_CYCLES-1, the debounced level flips and the counter clears.
//   - Rising edge of the debounced level gives an internal 1-cycle press pulse.
//   - Release edges produce no pulse. Glitches shorter than DB_CYCLES produce no pulse.
//   Dividers (free-running)
//   - div1 counts 0..TICK_DIV-1 and wraps. tick_1hz fires when div1 == TICK_DIV-1.
//   - tick_2hz fires when div1 == TICK_DIV/2-1 and when div1 == TICK_DIV-1.
//   - divf counts 0..FAST_DIV-1 and wraps. tick_fast fires when divf == FAST_DIV-1.
//   - Ticks are registered: 1 cycle after the compare.
//   FSM
//   - RUN -> PAUSED on a pause press; PAUSED -> RUN on a pause press.
//   - paused = (state == PAUSED).
//   cnt_en (registered)
//   - 0 in PAUSED.
//   - In RUN with adjust off: tick_1hz.
//   - In RUN with adjust on: tick_2hz.
//   Clear press
//   - cnt_clr pulses 1 cycle.
//   - div1 reloads to 0, so the next tick_1hz comes exactly TICK_DIV cycles later.
//   - FSM state is unchanged (see CONFIGURATION).
//   - divf and blink are unaffected.
//   Simultaneous events
//   - Clear with a tick: cnt_clr = 1 and cnt_en = 0 in that cycle.
//   - Clear with pause: both take effect.
//   - Adjust switch toggling mid-run: cnt_en source changes on the next tick; no extra pulse.
//   - Reset mid-debounce or mid-count: everything returns to reset values the next cycle; no pulses.
// CONFIGURATION
//   CLR_FORCE_PAUSE_EN
//   - Defined: a clear press also forces FSM = PAUSED. A pause press in the same cycle is ignored.
//   - Undefined: clear leaves the FSM state unchanged.
// TESTING (bench parameters: DB_CYCLES=4, TICK_DIV=20, FAST_DIV=5)
//   1. Release reset, no input
//      -> tick_1hz every 20 cycles; tick_2hz every 10; tick_fast every 5.
//      -> cnt_en == tick_1hz; blink toggles every 10 cycles.
//   2. btn_pause high for 3 cycles, then low
//      -> no press; paused stays 0.
//   3. btn_pause high for 10 cycles
//      -> exactly one press; paused = 1 after 2+4+1 cycles; cnt_en stays 0 across 40 cycles.
//   4. A second 10-cycle pause press
//      -> paused = 0; cnt_en resumes on the next tick_1hz.
//   5. sw_adj = 1, sw_sel = 0
//      -> adj_min = 1 and adj_sec = 0 after 3 cycles; cnt_en every 10 cycles.
//      -> Then sw_sel = 1: adj_sec = 1.
//   6. Clear press landing on the cycle of a tick_1hz
//      -> cnt_clr = 1, cnt_en = 0 in that cycle; next tick_1hz 20 cycles later.
//      -> Repeat with CLR_FORCE_PAUSE_EN defined: paused = 1.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_ctrl
// Desc   : Button/switch front end and tick generation for the stopwatch counter.
//          Option macro CLR_FORCE_PAUSE_EN: a clear press also forces PAUSED.
// Rev    : 1.0
// ============================================================================

module stopwatch_ctrl #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned FAST_DIV  = 200_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause,
  input  logic btn_rst,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic tick_1hz,
  output logic tick_2hz,
  output logic tick_fast,
  output logic cnt_en,
  output logic cnt_clr,
  output logic adj_min,
  output logic adj_sec,
  output logic paused,
  output logic blink
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned DIV1_W = $clog2(TICK_DIV);
  localparam int unsigned DIVF_W = $clog2(FAST_DIV);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV1_W-1:0] DIV1_LAST = DIV1_W'(TICK_DIV - 1);
  localparam logic [DIV1_W-1:0] DIV1_HALF = DIV1_W'(TICK_DIV / 2 - 1);
  localparam logic [DIVF_W-1:0] DIVF_LAST = DIVF_W'(FAST_DIV - 1);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  // Bit order in the synchroniser vectors: 0 pause, 1 clear, 2 adjust, 3 select.
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        sync2_q, sync2_d;
  logic [1:0]        db_q, db_d;
  logic [1:0]        press_q, press_d;
  logic [DB_W-1:0]   db_cnt_q [2];
  logic [DB_W-1:0]   db_cnt_d [2];
  logic [DIV1_W-1:0] div1_q, div1_d;
  logic [DIVF_W-1:0] divf_q, divf_d;
  logic              tick_1hz_q, tick_1hz_d;
  logic              tick_2hz_q, tick_2hz_d;
  logic              tick_fast_q, tick_fast_d;
  logic              cnt_en_q, cnt_en_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              adj_min_q, adj_min_d;
  logic              adj_sec_q, adj_sec_d;
  logic              blink_q, blink_d;
  state_t            state_q, state_d;

  logic cmp_1hz, cmp_2hz, cmp_fast, adj_on, pause_evt, clr_evt;

  assign cmp_1hz   = (div1_q == DIV1_LAST);
  assign cmp_2hz   = cmp_1hz | (div1_q == DIV1_HALF);
  assign cmp_fast  = (divf_q == DIVF_LAST);
  assign adj_on    = adj_min_q | adj_sec_q;
  assign pause_evt = press_q[0];
  assign clr_evt   = press_q[1];

  always_comb begin
    sync1_d     = {sw_sel, sw_adj, btn_rst, btn_pause};
    sync2_d     = sync1_q;
    db_d        = db_q;
    db_cnt_d[0] = '0;
    db_cnt_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    press_d     = db_d & ~db_q;

    adj_min_d   = sync2_q[2] & ~sync2_q[3];
    adj_sec_d   = sync2_q[2] & sync2_q[3];

    // A clear restarts the 1 Hz phase so a full period follows the clear.
    div1_d      = (clr_evt || cmp_1hz) ? '0 : div1_q + 1'b1;
    divf_d      = cmp_fast ? '0 : divf_q + 1'b1;
    tick_1hz_d  = cmp_1hz;
    tick_2hz_d  = cmp_2hz;
    tick_fast_d = cmp_fast;
    blink_d     = blink_q ^ cmp_2hz;

    cnt_clr_d   = clr_evt;
    cnt_en_d    = (state_q == RUN) && !clr_evt && (adj_on ? cmp_2hz : cmp_1hz);

    state_d     = state_q;
`ifdef CLR_FORCE_PAUSE_EN
    if (clr_evt) begin
      state_d = PAUSED;
    end else if (pause_evt) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end
`else
    if (pause_evt) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      press_q     <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      div1_q      <= '0;
      divf_q      <= '0;
      tick_1hz_q  <= 1'b0;
      tick_2hz_q  <= 1'b0;
      tick_fast_q <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
      adj_min_q   <= 1'b0;
      adj_sec_q   <= 1'b0;
      blink_q     <= 1'b0;
      state_q     <= RUN;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      press_q     <= press_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      div1_q      <= div1_d;
      divf_q      <= divf_d;
      tick_1hz_q  <= tick_1hz_d;
      tick_2hz_q  <= tick_2hz_d;
      tick_fast_q <= tick_fast_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
      adj_min_q   <= adj_min_d;
      adj_sec_q   <= adj_sec_d;
      blink_q     <= blink_d;
      state_q     <= state_d;
    end
  end

  assign tick_1hz  = tick_1hz_q;
  assign tick_2hz  = tick_2hz_q;
  assign tick_fast = tick_fast_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign adj_min   = adj_min_q;
  assign adj_sec   = adj_sec_q;
  assign blink     = blink_q;
  assign paused    = (state_q == PAUSED);

endmodule

`default_nettype wire
